// File: rtl/fir_pkg.sv
// Shared definitions for the FIR engine family: AXI-Lite register offsets,
// ap_ctrl bit positions and the sequencing FSM state encoding.
package fir_pkg;

    localparam logic [11:0] ADDR_AP_CTRL   = 12'h000;
    localparam logic [11:0] ADDR_LEN       = 12'h010;
    localparam logic [11:0] ADDR_TAPS      = 12'h014;
    localparam logic [11:0] ADDR_COEF_BASE = 12'h040;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MAC  = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } fir_state_e;

endpackage

// File: rtl/fir_mc_if.sv
// Bus bundle for fir_mc: AXI-Lite configuration channel plus the tagged
// AXI-Stream sample input and result output.
interface fir_mc_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pCH_WIDTH   = 1
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;

    logic                   ss_tvalid;
    logic                   ss_tready;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic [pCH_WIDTH-1:0]   ss_tuser;
    logic                   ss_tlast;

    logic                   sm_tvalid;
    logic                   sm_tready;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic [pCH_WIDTH-1:0]   sm_tuser;
    logic                   sm_tlast;

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output ss_tvalid, ss_tdata, ss_tuser, ss_tlast, sm_tready,
        input  awready, wready, arready, rvalid, rdata,
        input  ss_tready, sm_tvalid, sm_tdata, sm_tuser, sm_tlast
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  ss_tvalid, ss_tdata, ss_tuser, ss_tlast, sm_tready,
        output awready, wready, arready, rvalid, rdata,
        output ss_tready, sm_tvalid, sm_tdata, sm_tuser, sm_tlast
    );

endinterface

// File: rtl/fir_axil_regs.sv
// AXI-Lite slave and configuration register file (ap_ctrl, data_length,
// tap_num, coefficients). Config writes are dropped while the engine is busy.
module fir_axil_regs
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pMAX_TAPS   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  awvalid,
    output logic                                  awready,
    input  logic [pADDR_WIDTH-1:0]                awaddr,
    input  logic                                  wvalid,
    output logic                                  wready,
    input  logic [pDATA_WIDTH-1:0]                wdata,
    input  logic                                  arvalid,
    output logic                                  arready,
    input  logic [pADDR_WIDTH-1:0]                araddr,
    output logic                                  rvalid,
    input  logic                                  rready,
    output logic [pDATA_WIDTH-1:0]                rdata,
    input  logic                                  idle,
    input  logic                                  done,
    output logic                                  ap_start,
    output logic [pDATA_WIDTH-1:0]                data_length,
    output logic [pDATA_WIDTH-1:0]                tap_num,
    output logic [pMAX_TAPS-1:0][pDATA_WIDTH-1:0] coef
);

    localparam int CIDX_W = (pMAX_TAPS > 1) ? $clog2(pMAX_TAPS) : 1;

    localparam logic [pADDR_WIDTH-1:0] A_CTRL     = pADDR_WIDTH'(ADDR_AP_CTRL);
    localparam logic [pADDR_WIDTH-1:0] A_LEN      = pADDR_WIDTH'(ADDR_LEN);
    localparam logic [pADDR_WIDTH-1:0] A_TAPS     = pADDR_WIDTH'(ADDR_TAPS);
    localparam logic [pADDR_WIDTH-1:0] A_COEF     = pADDR_WIDTH'(ADDR_COEF_BASE);
    localparam logic [pADDR_WIDTH-1:0] A_COEF_END = pADDR_WIDTH'(32'(ADDR_COEF_BASE) + 32'(4 * pMAX_TAPS));
    localparam logic [pDATA_WIDTH-1:0] TAPS_MAX   = pDATA_WIDTH'(pMAX_TAPS);

    logic                                  wr_ack_r;
    logic                                  wr_fire_s;
    logic                                  start_r;
    logic [pDATA_WIDTH-1:0]                data_length_r;
    logic [pDATA_WIDTH-1:0]                tap_num_r;
    logic [pMAX_TAPS-1:0][pDATA_WIDTH-1:0] coef_r;
    logic                                  arready_r;
    logic                                  rvalid_r;
    logic [pDATA_WIDTH-1:0]                rdata_r;
    logic [pDATA_WIDTH-1:0]                rd_val_s;

    function automatic logic coef_hit(input logic [pADDR_WIDTH-1:0] a);
        return (a >= A_COEF) && (a < A_COEF_END);
    endfunction

    function automatic logic [CIDX_W-1:0] coef_idx(input logic [pADDR_WIDTH-1:0] a);
        return CIDX_W'((a - A_COEF) >> 2);
    endfunction

    assign awready     = wr_ack_r;
    assign wready      = wr_ack_r;
    assign wr_fire_s   = wr_ack_r && awvalid && wvalid;
    assign ap_start    = start_r;
    assign data_length = data_length_r;
    assign tap_num     = tap_num_r;
    assign coef        = coef_r;
    assign arready     = arready_r;
    assign rvalid      = rvalid_r;
    assign rdata       = rdata_r;

    // One-cycle address/data acknowledge once both halves are presented
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack_r <= 1'b0;
        end else begin
            wr_ack_r <= awvalid && wvalid && !wr_ack_r;
        end
    end

    // Register file update; start is only forwarded while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_r       <= 1'b0;
            data_length_r <= '0;
            tap_num_r     <= '0;
            coef_r        <= '0;
        end else begin
            start_r <= 1'b0;
            if (wr_fire_s) begin
                if (awaddr == A_CTRL) begin
                    start_r <= wdata[AP_START_BIT] && idle;
                end else if (idle) begin
                    if (awaddr == A_LEN) begin
                        data_length_r <= wdata;
                    end else if (awaddr == A_TAPS) begin
                        tap_num_r <= (wdata > TAPS_MAX) ? TAPS_MAX : wdata;
                    end else if (coef_hit(awaddr)) begin
                        coef_r[coef_idx(awaddr)] <= wdata;
                    end
                end
            end
        end
    end

    // Read mux; coefficients are masked while the MAC may be using them
    always_comb begin
        rd_val_s = '0;
        if (araddr == A_CTRL) begin
            rd_val_s[AP_DONE_BIT] = done;
            rd_val_s[AP_IDLE_BIT] = idle;
        end else if (araddr == A_LEN) begin
            rd_val_s = data_length_r;
        end else if (araddr == A_TAPS) begin
            rd_val_s = tap_num_r;
        end else if (coef_hit(araddr)) begin
            rd_val_s = idle ? coef_r[coef_idx(araddr)] : '1;
        end else begin
            rd_val_s = '0;
        end
    end

    // Read channel: arready pulse, then rdata held under rvalid until rready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
        end else begin
            arready_r <= arvalid && !arready_r && !rvalid_r;
            if (arready_r && arvalid) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_val_s;
            end else if (rvalid_r && rready) begin
                rvalid_r <= 1'b0;
                rdata_r  <= '0;
            end
        end
    end

endmodule

// File: rtl/fir_mc.sv
// Multi-channel FIR engine: shared coefficients, one delay line per channel,
// one tap per cycle through a single multiplier; results tagged by channel.
module fir_mc
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pMAX_TAPS   = 16,
    parameter int pCHANNELS   = 2,
    parameter int pCH_WIDTH   = 1
) (
    input  logic     axis_clk,
    input  logic     axis_rst,
    fir_mc_if.slave  bus
);

    localparam int TIDX_W = (pMAX_TAPS > 1) ? $clog2(pMAX_TAPS) : 1;

    fir_state_e                                         state_r;
    fir_state_e                                         state_nx_s;
    logic [pCHANNELS-1:0][pMAX_TAPS-1:0][pDATA_WIDTH-1:0] dline_r;
    logic [pCH_WIDTH-1:0]                               ch_r;
    logic [pCH_WIDTH-1:0]                               ch_sel_s;
    logic [TIDX_W-1:0]                                  tap_idx_r;
    logic signed [pDATA_WIDTH-1:0]                      acc_r;
    logic [pDATA_WIDTH-1:0]                             count_r;
    logic                                               done_r;

    logic                                               ap_start_s;
    logic [pDATA_WIDTH-1:0]                             data_length_s;
    logic [pDATA_WIDTH-1:0]                             tap_num_s;
    logic [pMAX_TAPS-1:0][pDATA_WIDTH-1:0]              coef_s;

    logic signed [pDATA_WIDTH-1:0]                      coef_sel_s;
    logic signed [pDATA_WIDTH-1:0]                      x_sel_s;
    logic signed [pDATA_WIDTH-1:0]                      prod_s;
    logic                                               tap_active_s;
    logic                                               last_tap_s;
    logic                                               last_sample_s;
    logic                                               idle_s;
    logic                                               ss_tready_s;
    logic                                               sm_tvalid_s;

    fir_axil_regs #(
        .pADDR_WIDTH (pADDR_WIDTH),
        .pDATA_WIDTH (pDATA_WIDTH),
        .pMAX_TAPS   (pMAX_TAPS)
    ) u_regs (
        .clk         (axis_clk),
        .rst         (axis_rst),
        .awvalid     (bus.awvalid),
        .awready     (bus.awready),
        .awaddr      (bus.awaddr),
        .wvalid      (bus.wvalid),
        .wready      (bus.wready),
        .wdata       (bus.wdata),
        .arvalid     (bus.arvalid),
        .arready     (bus.arready),
        .araddr      (bus.araddr),
        .rvalid      (bus.rvalid),
        .rready      (bus.rready),
        .rdata       (bus.rdata),
        .idle        (idle_s),
        .done        (done_r),
        .ap_start    (ap_start_s),
        .data_length (data_length_s),
        .tap_num     (tap_num_s),
        .coef        (coef_s)
    );

    // Out-of-range channel ids fold onto channel 0
    assign ch_sel_s = (32'(bus.ss_tuser) < 32'(pCHANNELS)) ? bus.ss_tuser : '0;

    // Only the low pDATA_WIDTH product bits are kept; they are the same for
    // signed and unsigned operands, so a narrow multiply suffices.
    assign coef_sel_s    = coef_s[tap_idx_r];
    assign x_sel_s       = dline_r[ch_r][tap_idx_r];
    assign prod_s        = coef_sel_s * x_sel_s;
    assign tap_active_s  = pDATA_WIDTH'(tap_idx_r) < tap_num_s;
    assign last_tap_s    = (pDATA_WIDTH'(tap_idx_r) + pDATA_WIDTH'(1)) >= tap_num_s;
    assign last_sample_s = count_r == (data_length_s - pDATA_WIDTH'(1));

    assign bus.ss_tready = ss_tready_s;
    assign bus.sm_tvalid = sm_tvalid_s;
    assign bus.sm_tdata  = sm_tvalid_s ? acc_r : '0;
    assign bus.sm_tuser  = sm_tvalid_s ? ch_r : '0;
    assign bus.sm_tlast  = sm_tvalid_s && last_sample_s;

    // State register
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and stream-handshake decode
    always_comb begin
        state_nx_s  = state_r;
        idle_s      = 1'b0;
        ss_tready_s = 1'b0;
        sm_tvalid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                idle_s = 1'b1;
                if (ap_start_s) begin
                    state_nx_s = (data_length_s == '0) ? ST_DONE : ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                ss_tready_s = 1'b1;
                state_nx_s  = bus.ss_tvalid ? ST_MAC : ST_LOAD;
            end
            ST_MAC: begin
                state_nx_s = last_tap_s ? ST_OUT : ST_MAC;
            end
            ST_OUT: begin
                sm_tvalid_s = 1'b1;
                if (bus.sm_tready) begin
                    state_nx_s = last_sample_s ? ST_DONE : ST_LOAD;
                end else begin
                    state_nx_s = ST_OUT;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: delay-line shift, tap-serial MAC, result counter, done flag
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            dline_r   <= '0;
            ch_r      <= '0;
            tap_idx_r <= '0;
            acc_r     <= '0;
            count_r   <= '0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ap_start_s) begin
                        dline_r <= '0;
                        count_r <= '0;
                        acc_r   <= '0;
                        done_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (bus.ss_tvalid) begin
                        dline_r[ch_sel_s] <= {dline_r[ch_sel_s][pMAX_TAPS-2:0], bus.ss_tdata};
                        ch_r              <= ch_sel_s;
                        acc_r             <= '0;
                        tap_idx_r         <= '0;
                    end
                end
                ST_MAC: begin
                    if (tap_active_s) begin
                        acc_r <= acc_r + prod_s;
                    end
                    tap_idx_r <= tap_idx_r + TIDX_W'(1);
                end
                ST_OUT: begin
                    if (bus.sm_tready) begin
                        count_r <= count_r + pDATA_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b1;
                end
                default: begin
                    done_r <= done_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mc.sv
// Directed self-checking bench for fir_mc: single-channel regression,
// channel interleave, backpressure, busy-time config, mid-run reset, limits.
module tb_fir_mc;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int MT  = 16;
    localparam int NCH = 2;
    localparam int CW  = 1;

    logic axis_clk = 1'b0;
    logic axis_rst;

    fir_mc_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pCH_WIDTH(CW)) bus ();

    fir_mc #(
        .pADDR_WIDTH (AW),
        .pDATA_WIDTH (DW),
        .pMAX_TAPS   (MT),
        .pCHANNELS   (NCH),
        .pCH_WIDTH   (CW)
    ) dut (
        .axis_clk (axis_clk),
        .axis_rst (axis_rst),
        .bus      (bus)
    );

    always #5 axis_clk = ~axis_clk;

    int checks   = 0;
    int failures = 0;
    int out_hs   = 0;

    always @(posedge axis_clk) begin
        if (bus.sm_tvalid && bus.sm_tready) out_hs <= out_hs + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge axis_clk);
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.awaddr = a; bus.wdata = d;
        while (!bus.awready && n < 20) begin @(negedge axis_clk); n++; end
        check_eq("awready", 32'(bus.awready), 32'd1);
        check_eq("wready", 32'(bus.wready), 32'd1);
        @(negedge axis_clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    endtask

    task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
        int n;
        n = 0;
        @(negedge axis_clk);
        bus.arvalid = 1'b1; bus.araddr = a;
        while (!bus.arready && n < 20) begin @(negedge axis_clk); n++; end
        check_eq("arready", 32'(bus.arready), 32'd1);
        @(negedge axis_clk);
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        n = 0;
        while (!bus.rvalid && n < 20) begin @(negedge axis_clk); n++; end
        check_eq("rvalid", 32'(bus.rvalid), 32'd1);
        d = bus.rdata;
        @(negedge axis_clk);
        bus.rready = 1'b0;
    endtask

    task automatic send_sample(input logic [31:0] d, input logic [0:0] ch, input logic lst);
        int n;
        n = 0;
        @(negedge axis_clk);
        bus.ss_tvalid = 1'b1; bus.ss_tdata = d; bus.ss_tuser = ch; bus.ss_tlast = lst;
        while (!bus.ss_tready && n < 100) begin @(negedge axis_clk); n++; end
        check_eq("ss_tready", 32'(bus.ss_tready), 32'd1);
        @(negedge axis_clk);
        bus.ss_tvalid = 1'b0; bus.ss_tlast = 1'b0;
    endtask

    task automatic recv_result(output logic [31:0] d, output logic [0:0] u, output logic l);
        int n;
        n = 0;
        while (!bus.sm_tvalid && n < 100) begin @(negedge axis_clk); n++; end
        check_eq("sm_tvalid", 32'(bus.sm_tvalid), 32'd1);
        d = bus.sm_tdata; u = bus.sm_tuser; l = bus.sm_tlast;
        @(negedge axis_clk);
    endtask

    task automatic start_run(input logic [31:0] len);
        axil_write(12'h010, len);
        axil_write(12'h000, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] d;
        logic [0:0]  u;
        logic        l;
        int          exp_v;
        int          h0;
        int          ph;
        int          n;
        int          hist[600];
        int          c11[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
        int          t2_d[4] = '{1, 10, 2, 20};
        int          t2_u[4] = '{0, 1, 0, 1};
        int          t2_e[4] = '{1, 10, 4, 40};

        bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
        bus.ss_tvalid = 1'b0; bus.ss_tdata = '0; bus.ss_tuser = '0; bus.ss_tlast = 1'b0;
        bus.sm_tready = 1'b1;
        axis_rst = 1'b1;
        repeat (3) @(negedge axis_clk);
        check_eq("rst_ss_tready", 32'(bus.ss_tready), 32'd0);
        check_eq("rst_sm_tvalid", 32'(bus.sm_tvalid), 32'd0);
        axis_rst = 1'b0;
        axil_read(12'h000, rd); check_eq("rst_ap_ctrl", rd, 32'h0000_0004);
        axil_read(12'h014, rd); check_eq("rst_tap_num", rd, 32'd0);
        axil_read(12'h010, rd); check_eq("rst_data_len", rd, 32'd0);
        axil_read(12'h044, rd); check_eq("rst_coef1", rd, 32'd0);

        // 1: single-channel regression on channel 0 against a convolution model
        axil_write(12'h014, 32'd11);
        for (int k = 0; k < 11; k++) axil_write(12'h040 + 12'(4 * k), 32'(c11[k]));
        start_run(32'd600);
        for (int s = 0; s < 600; s++) begin
            ph = s % 40;
            hist[s] = (ph < 20) ? (ph - 10) : (30 - ph);
            send_sample(32'(hist[s]), 1'b0, s == 599);
            exp_v = 0;
            for (int i = 0; i < 11; i++) begin
                if (s - i >= 0) exp_v += c11[i] * hist[s - i];
            end
            recv_result(d, u, l);
            check_eq("t1_data", d, 32'(exp_v));
            check_eq("t1_tuser", 32'(u), 32'd0);
            check_eq("t1_tlast", 32'(l), 32'(s == 599));
        end
        axil_read(12'h000, rd); check_eq("t1_ap_ctrl", rd, 32'h0000_0006);
        axil_read(12'h04C, rd); check_eq("t1_coef3", rd, 32'd23);
        axil_read(12'h048, rd); check_eq("t1_coef2_neg", rd, 32'hFFFF_FFF7);
        axil_read(12'h018, rd); check_eq("t1_unmapped", rd, 32'd0);

        // 2: two-channel interleave, coef {1,2,3}
        axil_write(12'h014, 32'd3);
        axil_write(12'h040, 32'd1);
        axil_write(12'h044, 32'd2);
        axil_write(12'h048, 32'd3);
        start_run(32'd4);
        for (int k = 0; k < 4; k++) begin
            send_sample(32'(t2_d[k]), 1'(t2_u[k]), k == 3);
            recv_result(d, u, l);
            check_eq("t2_data", d, 32'(t2_e[k]));
            check_eq("t2_tuser", 32'(u), 32'(t2_u[k]));
            check_eq("t2_tlast", 32'(l), 32'(k == 3));
        end

        // 3: backpressure for 5 cycles while a result is pending
        h0 = out_hs;
        start_run(32'd2);
        bus.sm_tready = 1'b0;
        send_sample(32'd5, 1'b0, 1'b0);
        n = 0;
        while (!bus.sm_tvalid && n < 100) begin @(negedge axis_clk); n++; end
        for (int c = 0; c < 5; c++) begin
            check_eq("bp_tvalid", 32'(bus.sm_tvalid), 32'd1);
            check_eq("bp_tdata", bus.sm_tdata, 32'd5);
            check_eq("bp_tuser", 32'(bus.sm_tuser), 32'd0);
            check_eq("bp_ss_tready", 32'(bus.ss_tready), 32'd0);
            @(negedge axis_clk);
        end
        bus.sm_tready = 1'b1;
        recv_result(d, u, l);
        check_eq("bp_data0", d, 32'd5);
        send_sample(32'd7, 1'b1, 1'b1);
        recv_result(d, u, l);
        check_eq("bp_data1", d, 32'd7);
        check_eq("bp_tuser1", 32'(u), 32'd1);
        check_eq("bp_tlast1", 32'(l), 32'd1);
        check_eq("bp_count", 32'(out_hs - h0), 32'd2);

        // 4: configuration attempts while busy
        start_run(32'd2);
        send_sample(32'd3, 1'b0, 1'b0);
        recv_result(d, u, l);
        check_eq("busy_data0", d, 32'd3);
        axil_write(12'h040, 32'd99);
        axil_write(12'h014, 32'd1);
        axil_write(12'h000, 32'd1);
        axil_read(12'h040, rd); check_eq("busy_coef_rd", rd, 32'hFFFF_FFFF);
        axil_read(12'h000, rd); check_eq("busy_ap_ctrl", rd, 32'd0);
        send_sample(32'd4, 1'b0, 1'b1);
        recv_result(d, u, l);
        check_eq("busy_data1", d, 32'd10);
        check_eq("busy_tlast1", 32'(l), 32'd1);
        axil_read(12'h040, rd); check_eq("busy_coef_after", rd, 32'd1);
        axil_read(12'h014, rd); check_eq("busy_taps_after", rd, 32'd3);
        axil_read(12'h000, rd); check_eq("busy_ap_ctrl_after", rd, 32'h0000_0006);

        // 6: boundaries
        axil_write(12'h014, 32'd20);
        axil_read(12'h014, rd); check_eq("taps_clamp", rd, 32'd16);
        h0 = out_hs;
        start_run(32'd0);
        repeat (6) @(negedge axis_clk);
        axil_read(12'h000, rd); check_eq("len0_ap_ctrl", rd, 32'h0000_0006);
        check_eq("len0_no_output", 32'(out_hs - h0), 32'd0);
        axil_write(12'h014, 32'd1);
        axil_write(12'h040, 32'h7FFF_FFFF);
        start_run(32'd1);
        send_sample(32'd2, 1'b1, 1'b1);
        recv_result(d, u, l);
        check_eq("wrap_data", d, 32'hFFFF_FFFE);
        check_eq("wrap_tuser", 32'(u), 32'd1);
        check_eq("wrap_tlast", 32'(l), 32'd1);

        // 5: reset while the MAC is running, with a read response pending
        axil_write(12'h014, 32'd16);
        start_run(32'd5);
        send_sample(32'd1, 1'b0, 1'b0);
        @(negedge axis_clk);
        bus.arvalid = 1'b1; bus.araddr = 12'h014;
        n = 0;
        while (!bus.arready && n < 20) begin @(negedge axis_clk); n++; end
        @(negedge axis_clk);
        bus.arvalid = 1'b0;
        check_eq("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
        check_eq("pre_rst_rdata", bus.rdata, 32'd16);
        check_eq("pre_rst_in_mac", 32'(bus.sm_tvalid), 32'd0);
        h0 = out_hs;
        #2 axis_rst = 1'b1;
        #1;
        check_eq("rst_async_rvalid", 32'(bus.rvalid), 32'd0);
        check_eq("rst_async_rdata", bus.rdata, 32'd0);
        check_eq("rst_async_arready", 32'(bus.arready), 32'd0);
        check_eq("rst_async_awready", 32'(bus.awready), 32'd0);
        check_eq("rst_async_ss_tready", 32'(bus.ss_tready), 32'd0);
        check_eq("rst_async_sm_tvalid", 32'(bus.sm_tvalid), 32'd0);
        check_eq("rst_async_sm_tdata", bus.sm_tdata, 32'd0);
        check_eq("rst_async_sm_tlast", 32'(bus.sm_tlast), 32'd0);
        repeat (2) @(negedge axis_clk);
        axis_rst = 1'b0;
        repeat (20) @(negedge axis_clk);
        check_eq("rst_no_output", 32'(out_hs - h0), 32'd0);
        axil_read(12'h000, rd); check_eq("rst2_ap_ctrl", rd, 32'h0000_0004);
        axil_read(12'h040, rd); check_eq("rst2_coef0", rd, 32'd0);
        axil_read(12'h014, rd); check_eq("rst2_tap_num", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_mc.md
Name: fir_mc

Overview:
- Parametrised, multi-channel successor of the single-channel FIR engine.
- Holds one coefficient set, shared by all channels, and a private delay line per channel in internal registers, so there is no external BRAM.
- Samples arrive on AXI-Stream tagged with a channel id; filtered results leave on AXI-Stream with the same tag.
- Configuration and ap_ctrl use the existing AXI-Lite register map.

Parameters:
pADDR_WIDTH  12  AXI-Lite address width
pDATA_WIDTH  32  sample/coefficient/result width (signed)
pMAX_TAPS    16  maximum tap count supported by storage
pCHANNELS    2   number of independent delay lines
pCH_WIDTH    1   channel id width, equal to clog2(pCHANNELS) with a minimum of 1

Ports:
axis_clk   in  1  single clock
axis_rst   in  1  asynchronous, active-high reset
awvalid    in  1  AXI-Lite write address valid
awready    out 1  AXI-Lite write address ready
awaddr     in  pADDR_WIDTH  write address
wvalid     in  1  write data valid
wready     out 1  write data ready
wdata      in  pDATA_WIDTH  write data
arvalid    in  1  read address valid
arready    out 1  read address ready
araddr     in  pADDR_WIDTH  read address
rvalid     out 1  read data valid
rready     in  1  read data ready
rdata      out pDATA_WIDTH  read data
ss_tvalid  in  1  input sample valid
ss_tready  out 1  input sample ready
ss_tdata   in  pDATA_WIDTH  input sample
ss_tuser   in  pCH_WIDTH  input channel id
ss_tlast   in  1  last input sample
sm_tvalid  out 1  output valid
sm_tready  in  1  output ready
sm_tdata   out pDATA_WIDTH  filtered result
sm_tuser   out pCH_WIDTH  channel id of result
sm_tlast   out 1  last result

Behaviour:
- Reset clears all of the following to 0: outputs, registers, delay lines, coefficients, tap_num, data_length. ap_idle=1 after reset.
- Reset asserted mid-operation aborts immediately; no output is completed.
- Register map:
  - 0x00 ap_ctrl: bit0 start (write-1), bit1 done, bit2 idle.
  - 0x10 data_length: total sample count across all channels.
  - 0x14 tap_num: values 1..pMAX_TAPS; values above the range are clamped to pMAX_TAPS.
  - 0x40+4k coef[k], k<pMAX_TAPS.
  - Unmapped reads return 0.
- AXI-Lite write: awready=wready=1 for exactly one cycle once both awvalid and wvalid are high. Writes to 0x10/0x14/0x40+ while not idle are acknowledged and discarded.
- AXI-Lite read: arready pulses for one cycle. rvalid rises the next cycle and holds rdata until rready. Coefficient reads while busy return 0xFFFFFFFF.
- ap_start is honoured only when idle. It clears done and idle, zeroes all delay lines, zeroes the sample counter, and enters LOAD. Start written while busy is ignored.
- FSM:
  - IDLE: idle=1.
  - LOAD: ss_tready=1. On a handshake, shift ss_tdata into the delay line of channel ss_tuser (a ss_tuser >= pCHANNELS maps to channel 0), latch the channel, go to MAC.
  - MAC: one tap per cycle, acc += coef[i]*x[ch][i] for i=0..tap_num-1. After tap_num cycles go to OUT.
  - OUT: sm_tvalid=1 and sm_tdata/tuser are held until sm_tready. sm_tlast=1 when the counter equals data_length-1. After the handshake, increment the counter; go to DONE if the last result was sent, else LOAD.
  - DONE: done=1, next cycle IDLE with idle=1. done stays sticky until the next start.
- Latency: the ss handshake to sm_tvalid is tap_num+1 cycles. ss_tready is 0 outside LOAD, so there is no buffering.
- Arithmetic: signed pDATA_WIDTH × pDATA_WIDTH product, truncated to pDATA_WIDTH. The accumulator is pDATA_WIDTH wide and wraps modulo 2^pDATA_WIDTH.
- ss_tlast is informational only. Completion is set by data_length; an early ss_tlast does not end the run.
- data_length=0 with a start goes directly to DONE with no output.

Decomposition:
- Shared package fir_pkg holds the following, all reused by the single-channel FIR:
  - register offsets: ADDR_AP_CTRL, ADDR_LEN, ADDR_TAPS, ADDR_COEF_BASE;
  - ap_ctrl bit indices;
  - the FSM state enum.
- One sub-module, fir_axil_regs, holds the AXI-Lite handshakes plus the register file. The top level keeps the FSM, delay lines and MAC.

Test Plan:
1. Single-channel regression with pCHANNELS=1, tap_num=11, coef {0,-10,-9,23,56,63,56,23,-9,-10,0}, 600 triangular-wave samples:
   - every sm_tdata matches the golden file;
   - sm_tlast is set on result 599;
   - after the run, reading 0x00 gives done=1 and idle=1.
2. Two-channel interleave, tap_num=3, coef {1,2,3}:
   - input ch0:1, ch1:10, ch0:2, ch1:20;
   - expected outputs (ch0,1), (ch1,10), (ch0,4), (ch1,40).
3. Backpressure: sm_tready is held low for 5 cycles in OUT:
   - sm_tdata and sm_tuser stay stable;
   - ss_tready stays 0;
   - no sample is lost.
4. Busy-time config:
   - writing coef[0]=99 mid-run, then reading 0x40 after done, returns the original value;
   - a mid-run read of 0x40 returns 0xFFFFFFFF;
   - a mid-run read of 0x00 gives idle=0.
5. Reset mid-run: assert axis_rst during MAC:
   - all outputs drop to 0 asynchronously;
   - after release, idle=1 and coef reads return 0.
6. Boundaries:
   - tap_num=20 reads back as 16;
   - data_length=0 with start gives done=1 with no sm_tvalid;
   - a product of 0x7FFFFFFF × 2 wraps to 0xFFFFFFFE.
